// File: rtl/fixture_picobello_top.sv
// Test fixture sequencer: SoC reset, binary preload handshake, end-of-computation capture,
// and UART frame tracking so the run only finishes once the console line is quiet.
module fixture_picobello_top #(
  parameter int unsigned RST_CYCLES   = 16,
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic [1:0]  boot_mode_i,
  input  logic [1:0]  preload_mode_i,
  input  logic        snitch_preload_i,
  output logic        soc_rst_o,
  output logic        preload_req_o,
  output logic [2:0]  preload_sel_o,
  output logic        preload_snitch_o,
  input  logic        preload_done_i,
  input  logic        eoc_valid_i,
  input  logic [31:0] eoc_data_i,
  input  logic        uart_rx_i,
  output logic        uart_reading_byte_o,
  output logic [31:0] exit_code_o,
  output logic        finish_o,
  output logic        error_o,
  output logic [1:0]  err_code_o
);

  localparam int unsigned FrameLen = 10 * CLKS_PER_BIT;
  localparam int unsigned RstW     = $clog2(RST_CYCLES + 2);
  localparam int unsigned UartW    = $clog2(FrameLen + 1);
  localparam logic [RstW-1:0]  RstLoad  = RstW'(RST_CYCLES);
  localparam logic [UartW-1:0] UartLoad = UartW'(FrameLen - 1);

  typedef enum logic [2:0] {
    StIdle, StReset, StPreSn, StPreMain, StWaitEoc, StDrain, StFinish, StError
  } state_e;

  state_e           state_q;
  logic [RstW-1:0]  rst_cnt_q;
  logic [1:0]       boot_q;
  logic [1:0]       preload_q;
  logic             snitch_q;

  logic             rx_q;
  logic [UartW-1:0] uart_cnt_q;
  logic             uart_start;
  logic             uart_busy_d;

  // Start bit is a high-to-low transition; edges inside a frame are ignored.
  assign uart_start = rx_q & ~uart_rx_i & ~uart_reading_byte_o;

  always_comb begin
    uart_busy_d = uart_start;
    if (uart_reading_byte_o) begin
      uart_busy_d = (uart_cnt_q != '0);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rx_q                <= 1'b1;
      uart_cnt_q          <= '0;
      uart_reading_byte_o <= 1'b0;
    end else begin
      rx_q                <= uart_rx_i;
      uart_reading_byte_o <= uart_busy_d;
      if (uart_start) begin
        uart_cnt_q <= UartLoad;
      end else if (uart_reading_byte_o && uart_cnt_q != '0) begin
        uart_cnt_q <= uart_cnt_q - UartW'(1);
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q          <= StIdle;
      rst_cnt_q        <= '0;
      boot_q           <= '0;
      preload_q        <= '0;
      snitch_q         <= 1'b0;
      soc_rst_o        <= 1'b1;
      preload_req_o    <= 1'b0;
      preload_snitch_o <= 1'b0;
      exit_code_o      <= '0;
      finish_o         <= 1'b0;
      error_o          <= 1'b0;
      err_code_o       <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (start_i) begin
            state_q   <= StReset;
            rst_cnt_q <= RstLoad;
            boot_q    <= boot_mode_i;
            preload_q <= preload_mode_i;
            snitch_q  <= snitch_preload_i;
            soc_rst_o <= 1'b1;
          end
        end
        StReset: begin
          if (rst_cnt_q <= RstW'(1)) begin
            soc_rst_o <= 1'b0;
            if (boot_q == 2'd1) begin
              state_q    <= StError;
              error_o    <= 1'b1;
              err_code_o <= 2'd3;
            end else if (boot_q[1]) begin
              state_q <= StWaitEoc;
            end else if (preload_q == 2'd3) begin
              state_q    <= StError;
              error_o    <= 1'b1;
              err_code_o <= 2'd1;
            end else if (preload_q == 2'd2 && snitch_q) begin
              state_q    <= StError;
              error_o    <= 1'b1;
              err_code_o <= 2'd2;
            end else begin
              state_q          <= snitch_q ? StPreSn : StPreMain;
              preload_req_o    <= 1'b1;
              preload_snitch_o <= snitch_q;
            end
          end else begin
            rst_cnt_q <= rst_cnt_q - RstW'(1);
          end
        end
        StPreSn: begin
          if (preload_done_i) begin
            state_q          <= StPreMain;
            preload_snitch_o <= 1'b0;
          end
        end
        StPreMain: begin
          if (preload_done_i) begin
            state_q       <= StWaitEoc;
            preload_req_o <= 1'b0;
          end
        end
        StWaitEoc: begin
          if (eoc_valid_i && eoc_data_i[0]) begin
            exit_code_o <= {1'b0, eoc_data_i[31:1]};
            state_q     <= StDrain;
          end
        end
        StDrain: begin
          // Next-state flag so finish rises in the same cycle the frame ends.
          if (!uart_busy_d) begin
            state_q  <= StFinish;
            finish_o <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    preload_sel_o = 3'b000;
    if (state_q == StPreSn || state_q == StPreMain) begin
      case (preload_q)
        2'd0:    preload_sel_o = 3'b001;
        2'd1:    preload_sel_o = 3'b010;
        2'd2:    preload_sel_o = 3'b100;
        default: preload_sel_o = 3'b000;
      endcase
    end
  end

endmodule

// File: tb/tb_fixture_picobello_top.sv
// Self-checking bench for fixture_picobello_top: directed scenarios plus randomized runs
// checked against a rule-level model of dispatch, preload sequence and UART frame length.
module tb_fixture_picobello_top;

  localparam int unsigned RstCycles  = 16;
  localparam int unsigned ClksPerBit = 16;
  localparam int unsigned FrameLen   = 10 * ClksPerBit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  boot = 2'd0;
  logic [1:0]  pre = 2'd0;
  logic        sn = 1'b0;
  logic        done = 1'b0;
  logic        eoc_valid = 1'b0;
  logic [31:0] eoc_data = 32'd0;
  logic        rx = 1'b1;

  logic        soc_rst_o;
  logic        preload_req_o;
  logic [2:0]  preload_sel_o;
  logic        preload_snitch_o;
  logic        uart_reading_byte_o;
  logic [31:0] exit_code_o;
  logic        finish_o;
  logic        error_o;
  logic [1:0]  err_code_o;

  int checks = 0;
  int errors = 0;

  fixture_picobello_top #(
    .RST_CYCLES   (RstCycles),
    .CLKS_PER_BIT (ClksPerBit)
  ) dut (
    .clk_i               (clk),
    .rst_i               (rst),
    .start_i             (start),
    .boot_mode_i         (boot),
    .preload_mode_i      (pre),
    .snitch_preload_i    (sn),
    .soc_rst_o           (soc_rst_o),
    .preload_req_o       (preload_req_o),
    .preload_sel_o       (preload_sel_o),
    .preload_snitch_o    (preload_snitch_o),
    .preload_done_i      (done),
    .eoc_valid_i         (eoc_valid),
    .eoc_data_i          (eoc_data),
    .uart_rx_i           (rx),
    .uart_reading_byte_o (uart_reading_byte_o),
    .exit_code_o         (exit_code_o),
    .finish_o            (finish_o),
    .error_o             (error_o),
    .err_code_o          (err_code_o)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1; start = 1'b0; done = 1'b0; eoc_valid = 1'b0; rx = 1'b1;
    tick(); tick();
    rst = 1'b0;
    tick();
  endtask

  // Expected error code from the configuration; 0 means the run proceeds.
  function automatic logic [1:0] model_err(input logic [1:0] b, input logic [1:0] p,
                                           input logic s);
    if (b == 2'd1) return 2'd3;
    if (b >= 2'd2) return 2'd0;
    if (p == 2'd3) return 2'd1;
    if (p == 2'd2 && s) return 2'd2;
    return 2'd0;
  endfunction

  task automatic run_case(input string name, input logic [1:0] b, input logic [1:0] p,
                          input logic s, input logic [30:0] code);
    logic [1:0] exp_err;
    logic [2:0] exp_sel;
    int         n;
    int         nreq;
    int         w;
    bit         seen_req;
    apply_reset();
    boot = b; pre = p; sn = s; start = 1'b1;
    tick();
    start = 1'b0;
    boot = ~b; pre = ~p; sn = ~s;
    n = 0;
    while (soc_rst_o === 1'b1 && n < 100) begin
      tick();
      n++;
    end
    checks++;
    if (n != RstCycles) begin
      errors++;
      $display("FAIL %s soc_rst_len: got %0d cycles, want %0d", name, n, RstCycles);
    end
    exp_err = model_err(b, p, s);
    if (exp_err != 2'd0) begin
      checks++;
      if (error_o !== 1'b1 || err_code_o !== exp_err || finish_o !== 1'b0) begin
        errors++;
        $display("FAIL %s error: got err=%b code=%0d fin=%b, want err=1 code=%0d fin=0",
                 name, error_o, err_code_o, finish_o, exp_err);
      end
      seen_req = 1'b0;
      for (int c = 0; c < 6; c++) begin
        if (preload_req_o !== 1'b0) seen_req = 1'b1;
        start = (c == 2);
        tick();
      end
      start = 1'b0;
      checks++;
      if (seen_req || error_o !== 1'b1 || err_code_o !== exp_err || soc_rst_o !== 1'b0) begin
        errors++;
        $display("FAIL %s error_terminal: req_seen=%b err=%b code=%0d soc_rst=%b, want 0/1/%0d/0",
                 name, seen_req, error_o, err_code_o, soc_rst_o, exp_err);
      end
      return;
    end
    nreq = (b == 2'd0) ? (s ? 2 : 1) : 0;
    exp_sel = 3'b001 << p;
    for (int r = 0; r < nreq; r++) begin
      w = $urandom_range(0, 4);
      for (int c = 0; c <= w; c++) begin
        checks++;
        if (preload_req_o !== 1'b1 || preload_sel_o !== exp_sel ||
            preload_snitch_o !== (s && r == 0)) begin
          errors++;
          $display("FAIL %s preload_req%0d: got req=%b sel=%b sn=%b, want 1/%b/%b",
                   name, r, preload_req_o, preload_sel_o, preload_snitch_o, exp_sel,
                   (s && r == 0));
        end
        if (c == w) done = 1'b1;
        tick();
        done = 1'b0;
      end
    end
    checks++;
    if (preload_req_o !== 1'b0 || preload_sel_o !== 3'b000 || soc_rst_o !== 1'b0) begin
      errors++;
      $display("FAIL %s req_idle: got req=%b sel=%b soc_rst=%b, want 0/000/0",
               name, preload_req_o, preload_sel_o, soc_rst_o);
    end
    done = 1'b1;
    tick();
    done = 1'b0;
    eoc_data = $urandom();
    eoc_data[0] = 1'b0;
    eoc_valid = 1'b1;
    tick();
    eoc_valid = 1'b0;
    tick(); tick();
    checks++;
    if (finish_o !== 1'b0 || exit_code_o !== 32'd0) begin
      errors++;
      $display("FAIL %s eoc_ignored: got fin=%b exit=%h, want 0/0", name, finish_o, exit_code_o);
    end
    eoc_data = {code, 1'b1};
    eoc_valid = 1'b1;
    tick();
    eoc_valid = 1'b0;
    eoc_data = 32'd0;
    tick();
    checks++;
    if (finish_o !== 1'b1 || exit_code_o !== {1'b0, code} || error_o !== 1'b0) begin
      errors++;
      $display("FAIL %s finish: got fin=%b exit=%h err=%b, want 1/%h/0",
               name, finish_o, exit_code_o, error_o, {1'b0, code});
    end
    boot = 2'd0; pre = 2'd0; sn = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    checks++;
    if (finish_o !== 1'b1 || soc_rst_o !== 1'b0 || preload_req_o !== 1'b0) begin
      errors++;
      $display("FAIL %s terminal: got fin=%b soc_rst=%b req=%b, want 1/0/0",
               name, finish_o, soc_rst_o, preload_req_o);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    checks++;
    if (soc_rst_o !== 1'b1 || preload_req_o !== 1'b0 || preload_sel_o !== 3'b000 ||
        preload_snitch_o !== 1'b0 || uart_reading_byte_o !== 1'b0 || exit_code_o !== 32'd0 ||
        finish_o !== 1'b0 || error_o !== 1'b0 || err_code_o !== 2'd0) begin
      errors++;
      $display("FAIL reset_values: got soc_rst=%b req=%b sel=%b sn=%b uart=%b exit=%h fin=%b err=%b code=%0d",
               soc_rst_o, preload_req_o, preload_sel_o, preload_snitch_o, uart_reading_byte_o,
               exit_code_o, finish_o, error_o, err_code_o);
    end
    rst = 1'b0;
    repeat (25) tick();
    checks++;
    if (soc_rst_o !== 1'b1 || preload_req_o !== 1'b0 || finish_o !== 1'b0) begin
      errors++;
      $display("FAIL idle_hold: got soc_rst=%b req=%b fin=%b, want 1/0/0",
               soc_rst_o, preload_req_o, finish_o);
    end
  endtask

  task automatic test_jtag_boot();
    run_case("jtag_boot", 2'd0, 2'd0, 1'b0, 31'd0);
  endtask

  task automatic test_serial_snitch();
    run_case("serial_snitch", 2'd0, 2'd1, 1'b1, 31'd3);
  endtask

  task automatic test_errors();
    run_case("err_uart_snitch", 2'd0, 2'd2, 1'b1, 31'd0);
    run_case("err_sd_boot", 2'd1, 2'd0, 1'b0, 31'd0);
    run_case("err_reserved", 2'd0, 2'd3, 1'b0, 31'd0);
  endtask

  task automatic test_autonomous();
    run_case("autonomous", 2'd2, 2'd0, 1'b0, 31'd2);
    run_case("uart_main", 2'd0, 2'd2, 1'b0, 31'h1234_5678);
  endtask

  task automatic test_random();
    for (int i = 0; i < 12; i++) begin
      run_case("random", 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
               1'($urandom_range(0, 1)), 31'($urandom()));
    end
  endtask

  task automatic test_uart_idle();
    int n;
    apply_reset();
    repeat ($urandom_range(1, 8)) tick();
    rx = 1'b0;
    tick();
    n = 0;
    while (uart_reading_byte_o === 1'b1 && n < FrameLen + 20) begin
      if (n == 20) rx = 1'b1;
      if (n == 40) rx = 1'b0;
      if (n == 60) rx = 1'b1;
      tick();
      n++;
    end
    checks++;
    if (n != FrameLen) begin
      errors++;
      $display("FAIL uart_frame_len: got %0d cycles, want %0d", n, FrameLen);
    end
  endtask

  // lead=1: start edge one cycle before the eoc write; lead=0: both in the same cycle.
  task automatic uart_drain_case(input string name, input int lead);
    int n;
    apply_reset();
    boot = 2'd3; start = 1'b1;
    tick();
    start = 1'b0;
    n = 0;
    while (soc_rst_o === 1'b1 && n < 100) begin
      tick();
      n++;
    end
    rx = 1'b0;
    if (lead == 0) begin
      eoc_valid = 1'b1;
      eoc_data = 32'h0000_000B;
    end
    tick();
    n = 0;
    if (lead == 1) begin
      eoc_valid = 1'b1;
      eoc_data = 32'h0000_000B;
      tick();
      n = 1;
    end
    eoc_valid = 1'b0;
    while (uart_reading_byte_o === 1'b1 && finish_o !== 1'b1 && n < FrameLen + 20) begin
      if (n == 30) rx = 1'b1;
      if (n == 50) rx = 1'b0;
      if (n == 70) rx = 1'b1;
      tick();
      n++;
    end
    checks++;
    if (n != FrameLen || uart_reading_byte_o !== 1'b0 || finish_o !== 1'b1 ||
        exit_code_o !== 32'd5) begin
      errors++;
      $display("FAIL %s: got n=%0d uart=%b fin=%b exit=%h, want n=%0d 0/1/5",
               name, n, uart_reading_byte_o, finish_o, exit_code_o, FrameLen);
    end
  endtask

  task automatic test_uart_drain();
    uart_drain_case("uart_drain_lead", 1);
    uart_drain_case("uart_drain_same", 0);
  endtask

  task automatic test_mid_reset();
    int n;
    apply_reset();
    boot = 2'd0; pre = 2'd0; sn = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    n = 0;
    while (soc_rst_o === 1'b1 && n < 100) begin
      tick();
      n++;
    end
    rx = 1'b0;
    tick();
    checks++;
    if (preload_req_o !== 1'b1 || uart_reading_byte_o !== 1'b1) begin
      errors++;
      $display("FAIL mid_reset_setup: got req=%b uart=%b, want 1/1",
               preload_req_o, uart_reading_byte_o);
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (soc_rst_o !== 1'b1 || preload_req_o !== 1'b0 || preload_sel_o !== 3'b000 ||
        uart_reading_byte_o !== 1'b0 || finish_o !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_async: got soc_rst=%b req=%b sel=%b uart=%b fin=%b, want 1/0/000/0/0",
               soc_rst_o, preload_req_o, preload_sel_o, uart_reading_byte_o, finish_o);
    end
    rx = 1'b1;
    tick();
    rst = 1'b0;
    repeat (4) tick();
    checks++;
    if (soc_rst_o !== 1'b1 || preload_req_o !== 1'b0 || uart_reading_byte_o !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_idle: got soc_rst=%b req=%b uart=%b, want 1/0/0",
               soc_rst_o, preload_req_o, uart_reading_byte_o);
    end
    run_case("after_reset", 2'd0, 2'd0, 1'b0, 31'd9);
  endtask

  initial begin
    test_reset();
    test_jtag_boot();
    test_serial_snitch();
    test_errors();
    test_autonomous();
    test_uart_idle();
    test_uart_drain();
    test_mid_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

endmodule
